// File: rtl/store_monitor_if.sv
// store_monitor_if: data-memory store bus of the core.
// master = core side, slave = monitor side.
interface store_monitor_if #(
  parameter int DW = 64
);
  logic [1:0]    memwrite;
  logic [DW-1:0] dataadr;
  logic [DW-1:0] writedata;

  modport master (
    output memwrite,
    output dataadr,
    output writedata
  );

  modport slave (
    input memwrite,
    input dataadr,
    input writedata
  );
endinterface

// File: rtl/store_monitor.sv
// store_monitor: store-signature pass/timeout checker with cycle count.
// Optional store log FIFO enabled by defining STORE_MONITOR_LOG_EN.
module store_monitor #(
  parameter int DW       = 64,
  parameter int NSIG     = 8,
  parameter int TIMEOUT  = 1580,
  parameter int LOGDEPTH = 8,
  localparam int SW      = (NSIG > 1) ? $clog2(NSIG) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  store_monitor_if.slave    bus,
  input  logic              cfg_we,
  input  logic [SW-1:0]     cfg_idx,
  input  logic [DW-1:0]     cfg_adr,
  input  logic [DW-1:0]     cfg_dat,
  input  logic              cfg_vld,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [SW-1:0]     hit_idx,
  output logic [31:0]       cycles,
  output logic [31:0]       store_cnt,
  input  logic              log_rd,
  output logic [DW-1:0]     log_adr,
  output logic [DW-1:0]     log_dat,
  output logic              log_empty
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PASS,
    TOUT
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0]   sig_adr [NSIG];
  logic [DW-1:0]   sig_dat [NSIG];
  logic [NSIG-1:0] sig_vld;

  logic          st;
  logic          act;
  logic          hit;
  logic [SW-1:0] hit_nx;
  logic          last;

  assign st   = |bus.memwrite;
  assign act  = st && !start && (state == RUN);
  assign last = (cycles == 32'(TIMEOUT - 1));

  // lowest valid entry matching the current store, old table contents
  always_comb begin
    hit    = 1'b0;
    hit_nx = '0;
    for (int i = NSIG - 1; i >= 0; i--) begin
      if (sig_vld[i] &&
          sig_adr[i] == bus.dataadr &&
          sig_dat[i] == bus.writedata) begin
        hit    = 1'b1;
        hit_nx = SW'(i);
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next state: start dominates, match beats timeout
  always_comb begin
    state_nx = state;
    if (start)                state_nx = RUN;
    else if (state == RUN) begin
      if (act && hit)         state_nx = PASS;
      else if (last)          state_nx = TOUT;
    end
  end

  assign busy    = (state == RUN);
  assign pass    = (state == PASS);
  assign timeout = (state == TOUT);
  assign done    = pass || timeout;

  // run counters and latched hit index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles    <= '0;
      store_cnt <= '0;
      hit_idx   <= '0;
    end else if (start) begin
      cycles    <= '0;
      store_cnt <= '0;
      hit_idx   <= '0;
    end else if (state == RUN) begin
      cycles <= cycles + 32'd1;
      if (act && store_cnt != '1) store_cnt <= store_cnt + 32'd1;
      if (act && hit)             hit_idx   <= hit_nx;
    end
  end

  // signature valid bits, cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      sig_vld          <= '0;
    else if (cfg_we) sig_vld[cfg_idx] <= cfg_vld;
  end

  // signature address/data storage
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      sig_adr[cfg_idx] <= cfg_adr;
      sig_dat[cfg_idx] <= cfg_dat;
    end
  end

`ifdef STORE_MONITOR_LOG_EN
  localparam int LW = (LOGDEPTH > 1) ? $clog2(LOGDEPTH) : 1;

  logic [DW-1:0] lg_adr [LOGDEPTH];
  logic [DW-1:0] lg_dat [LOGDEPTH];
  logic [LW-1:0] head;
  logic [LW-1:0] tail;
  logic [LW:0]   cnt;
  logic          push;
  logic          pop;
  logic          full;

  assign push = st && !start;
  assign pop  = log_rd && (cnt != '0);
  assign full = (cnt == (LW+1)'(LOGDEPTH));
  assign tail = head + cnt[LW-1:0];

  // pointers: pop on old head, overwrite oldest when full
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      cnt  <= '0;
    end else begin
      head <= head + LW'(pop) + LW'(push && full && !pop);
      if (push && !pop && !full)  cnt <= cnt + 1'b1;
      else if (pop && !push)      cnt <= cnt - 1'b1;
    end
  end

  // log storage
  always_ff @(posedge clk) begin
    if (push) begin
      lg_adr[tail] <= bus.dataadr;
      lg_dat[tail] <= bus.writedata;
    end
  end

  assign log_empty = (cnt == '0);
  assign log_adr   = log_empty ? '0 : lg_adr[head];
  assign log_dat   = log_empty ? '0 : lg_dat[head];
`else
  logic unused_log;

  assign unused_log = log_rd ^ (LOGDEPTH == 0);
  assign log_adr    = '0;
  assign log_dat    = '0;
  assign log_empty  = 1'b1;
`endif

endmodule

// File: tb/tb_store_monitor.sv
// tb_store_monitor: randomized and directed checks against a
// behavioural model of store_monitor.
module tb_store_monitor;
  localparam int DW       = 64;
  localparam int NSIG     = 8;
  localparam int SW       = 3;
  localparam int TIMEOUT  = 1580;
  localparam int LOGDEPTH = 8;
  localparam int VW       = 200;

  logic          clk = 0;
  logic          reset = 0;
  logic          start = 0;
  logic          cfg_we = 0;
  logic [SW-1:0] cfg_idx = '0;
  logic [DW-1:0] cfg_adr = '0;
  logic [DW-1:0] cfg_dat = '0;
  logic          cfg_vld = 0;
  logic          log_rd = 0;
  logic          busy, done, pass, timeout;
  logic [SW-1:0] hit_idx;
  logic [31:0]   cycles, store_cnt;
  logic [DW-1:0] log_adr, log_dat;
  logic          log_empty;

  int checks = 0;
  int errors = 0;

  store_monitor_if #(.DW(DW)) bus ();

  store_monitor #(
    .DW(DW), .NSIG(NSIG), .TIMEOUT(TIMEOUT), .LOGDEPTH(LOGDEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr),
    .cfg_dat(cfg_dat), .cfg_vld(cfg_vld),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .hit_idx(hit_idx), .cycles(cycles), .store_cnt(store_cnt),
    .log_rd(log_rd), .log_adr(log_adr), .log_dat(log_dat),
    .log_empty(log_empty)
  );

  always #5 clk = ~clk;

  wire [VW-1:0] dut_vec = {busy, done, pass, timeout, hit_idx,
                           cycles, store_cnt, log_empty,
                           log_adr, log_dat};

  // behavioural model
  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic [DW-1:0]   m_adr [NSIG];
  logic [DW-1:0]   m_dat [NSIG];
  bit              m_vld [NSIG];
  bit              m_run, m_pass, m_tout;
  int unsigned     m_cyc;
  longint unsigned m_cnt;
  int              m_hit;
  ent_t            m_log [$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 0; m_pass = 0; m_tout = 0;
      m_cyc = 0; m_cnt = 0; m_hit = 0;
      for (int i = 0; i < NSIG; i++) m_vld[i] = 0;
      m_log.delete();
    end else begin
      bit st;
      int found;
      ent_t e;
      st = (bus.memwrite != 2'b00);
      found = -1;
      if (start) begin
        m_run = 1; m_pass = 0; m_tout = 0;
        m_cyc = 0; m_cnt = 0; m_hit = 0;
      end else if (m_run) begin
        m_cyc++;
        if (st) begin
          if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
          for (int i = 0; i < NSIG; i++)
            if (found < 0 && m_vld[i] && m_adr[i] == bus.dataadr &&
                m_dat[i] == bus.writedata) found = i;
        end
        if (found >= 0) begin
          m_run = 0; m_pass = 1; m_hit = found;
        end else if (m_cyc == TIMEOUT) begin
          m_run = 0; m_tout = 1;
        end
      end
      if (cfg_we) begin
        m_adr[cfg_idx] = cfg_adr;
        m_dat[cfg_idx] = cfg_dat;
        m_vld[cfg_idx] = cfg_vld;
      end
`ifdef STORE_MONITOR_LOG_EN
      if (log_rd && m_log.size() > 0) void'(m_log.pop_front());
      if (st && !start) begin
        e.a = bus.dataadr;
        e.d = bus.writedata;
        m_log.push_back(e);
        if (m_log.size() > LOGDEPTH) void'(m_log.pop_front());
      end
`endif
    end
  end

  function automatic logic [VW-1:0] exp_vec();
    logic [DW-1:0] ea, ed;
    logic ee;
    ee = 1; ea = '0; ed = '0;
`ifdef STORE_MONITOR_LOG_EN
    if (m_log.size() > 0) begin
      ee = 0; ea = m_log[0].a; ed = m_log[0].d;
    end
`endif
    return {m_run, m_pass | m_tout, m_pass, m_tout, SW'(m_hit),
            32'(m_cyc), 32'(m_cnt), ee, ea, ed};
  endfunction

  // stimulus helpers
  task automatic cyc();
    @(posedge clk);
    #1;
    start = 0; cfg_we = 0; log_rd = 0;
    bus.memwrite = 2'b00;
  endtask

  task automatic prog(input int idx, input logic [DW-1:0] a,
                      input logic [DW-1:0] d, input bit v);
    cfg_we = 1; cfg_idx = SW'(idx);
    cfg_adr = a; cfg_dat = d; cfg_vld = v;
    cyc();
  endtask

  task automatic drive_store(input logic [DW-1:0] a,
                             input logic [DW-1:0] d);
    bus.memwrite = 2'($urandom_range(1, 3));
    bus.dataadr = a;
    bus.writedata = d;
  endtask

  task automatic do_reset();
    reset = 0;
    cyc();
    reset = 1;
    cyc();
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (2) cyc();
    checks++;
    if (dut_vec !== (VW'(1) << 128)) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=%h", dut_vec, VW'(1) << 128);
    end
    reset = 1;
    cyc();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_pass();
    logic [31:0] frz;
    prog(0, 100, 7, 1);
    start = 1;
    cyc();
    for (int c = 1; c <= 12; c++) begin
      if (c == 4) drive_store(96, 3);
      if (c == 9) drive_store(100, 7);
      cyc();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL pass_cycle%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
    end
    checks++;
    if ({pass, timeout, hit_idx, store_cnt, cycles} !==
        {1'b1, 1'b0, 3'd0, 32'd2, 32'd9}) begin
      errors++;
      $display("FAIL pass_result got p=%b t=%b h=%0d n=%0d c=%0d exp p=1 t=0 h=0 n=2 c=9",
               pass, timeout, hit_idx, store_cnt, cycles);
    end
    frz = cycles;
    repeat (3) cyc();
    checks++;
    if (cycles !== frz) begin
      errors++;
      $display("FAIL pass_frozen got=%0d exp=%0d", cycles, frz);
    end
  endtask

  task automatic test_timeout();
    int n;
    prog(0, 100, 7, 1);
    start = 1;
    cyc();
    drive_store(100, 6);
    cyc();
    n = 0;
    while (!timeout && n < 2000) begin
      cyc();
      n++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL tout_cycle%0d got=%h exp=%h", n, dut_vec, exp_vec());
      end
    end
    checks++;
    if ({timeout, pass, cycles, store_cnt} !==
        {1'b1, 1'b0, 32'd1580, 32'd1}) begin
      errors++;
      $display("FAIL tout_result got t=%b p=%b c=%0d n=%0d exp t=1 p=0 c=1580 n=1",
               timeout, pass, cycles, store_cnt);
    end
  endtask

  task automatic test_priority();
    int n;
    do_reset();
    prog(2, 80, 1, 1);
    prog(5, 80, 1, 1);
    start = 1;
    cyc();
    drive_store(80, 1);
    cyc();
    checks++;
    if ({pass, hit_idx} !== {1'b1, 3'd2} || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL prio_idx got p=%b h=%0d exp p=1 h=2", pass, hit_idx);
    end
    start = 1;
    cyc();
    n = 0;
    while (cycles != 32'd1579 && n < 2000) begin
      cyc();
      n++;
    end
    drive_store(80, 1);
    cyc();
    checks++;
    if ({pass, timeout, hit_idx, cycles} !==
        {1'b1, 1'b0, 3'd2, 32'd1580} || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL prio_last got p=%b t=%b h=%0d c=%0d exp p=1 t=0 h=2 c=1580",
               pass, timeout, hit_idx, cycles);
    end
  endtask

  task automatic test_reset_midrun();
    prog(0, 100, 7, 1);
    start = 1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive_store(64'(200 + i), 64'(i));
      cyc();
    end
    reset = 0;
    #2;
    checks++;
    if (dut_vec !== (VW'(1) << 128)) begin
      errors++;
      $display("FAIL midrun_async got=%h exp=%h", dut_vec, VW'(1) << 128);
    end
    repeat (2) cyc();
    reset = 1;
    drive_store(100, 7);
    cyc();
    checks++;
    if ({busy, pass} !== 2'b00 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL midrun_idle got=%h exp=%h", dut_vec, exp_vec());
    end
    start = 1;
    cyc();
    drive_store(100, 7);
    cyc();
    checks++;
    if ({busy, pass, store_cnt} !== {1'b1, 1'b0, 32'd1} ||
        dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL midrun_cleared got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_restart();
    prog(0, 100, 7, 1);
    start = 1;
    cyc();
    drive_store(100, 7);
    cyc();
    checks++;
    if (pass !== 1'b1) begin
      errors++;
      $display("FAIL restart_pre got p=%b exp p=1", pass);
    end
    start = 1;
    drive_store(100, 7);
    cyc();
    checks++;
    if ({busy, pass, store_cnt, cycles} !== {1'b1, 1'b0, 32'd0, 32'd0} ||
        dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL restart got b=%b p=%b n=%0d c=%0d exp b=1 p=0 n=0 c=0",
               busy, pass, store_cnt, cycles);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < NSIG; i++)
      prog(i, 64'($urandom_range(0, 3) * 8), 64'($urandom_range(0, 3)),
           bit'($urandom_range(0, 1)));
    start = 1;
    cyc();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 39) == 0) start = 1;
      bus.memwrite = 2'($urandom_range(0, 3));
      bus.dataadr = 64'($urandom_range(0, 3) * 8);
      bus.writedata = ($urandom_range(0, 19) == 0) ?
                      {$urandom, $urandom} : 64'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        cfg_we = 1;
        cfg_idx = SW'($urandom_range(0, NSIG - 1));
        cfg_adr = 64'($urandom_range(0, 3) * 8);
        cfg_dat = 64'($urandom_range(0, 3));
        cfg_vld = 1'($urandom_range(0, 1));
      end
      log_rd = ($urandom_range(0, 3) == 0);
      cyc();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_log();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive_store(64'(i * 8), 64'(i));
      cyc();
    end
`ifdef STORE_MONITOR_LOG_EN
    for (int k = 2; k <= 9; k++) begin
      checks++;
      if ({log_empty, log_adr, log_dat} !== {1'b0, 64'(k * 8), 64'(k)}) begin
        errors++;
        $display("FAIL log_pop%0d got e=%b a=%0d d=%0d exp e=0 a=%0d d=%0d",
                 k, log_empty, log_adr, log_dat, k * 8, k);
      end
      log_rd = 1;
      cyc();
    end
`endif
    checks++;
    if (log_empty !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL log_empty got e=%b exp e=1", log_empty);
    end
    log_rd = 1;
    cyc();
    checks++;
    if ({log_empty, log_adr, log_dat} !== {1'b1, 128'd0} ||
        dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL log_extra_pop got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  initial begin
    bus.memwrite = 2'b00;
    bus.dataadr = '0;
    bus.writedata = '0;
    test_reset();
    test_pass();
    test_timeout();
    test_priority();
    test_reset_midrun();
    test_restart();
    test_random();
    test_log();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
